// File: rtl/binned_frame_upscaler_if.sv
// Bus bundle for binned_frame_upscaler.
//   master: binning stage + display timing source (drives bin writes and
//           display counters, observes the upscaled pixel stream)
//   slave : the upscaler itself
// Signals:
//   bin_valid_in/bin_hcount_in/bin_vcount_in/bin_pixel_in : binned pixel write
//   hcount_in/vcount_in                                   : display counters
//   pixel_out/valid_out/hcount_out/vcount_out             : 2-cycle delayed video
//   front_bank_out                                        : bank being displayed
//   range_err_out                                         : sticky bad-write flag
interface binned_frame_upscaler_if;
  logic        bin_valid_in;
  logic [8:0]  bin_hcount_in;
  logic [7:0]  bin_vcount_in;
  logic        bin_pixel_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        pixel_out;
  logic        valid_out;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        front_bank_out;
  logic        range_err_out;

  modport master (
    output bin_valid_in, bin_hcount_in, bin_vcount_in, bin_pixel_in,
    output hcount_in, vcount_in,
    input  pixel_out, valid_out, hcount_out, vcount_out,
    input  front_bank_out, range_err_out
  );

  modport slave (
    input  bin_valid_in, bin_hcount_in, bin_vcount_in, bin_pixel_in,
    input  hcount_in, vcount_in,
    output pixel_out, valid_out, hcount_out, vcount_out,
    output front_bank_out, range_err_out
  );
endinterface

// File: rtl/binned_frame_upscaler.sv
// Double-banked binned frame store with 4x4 replay at display timing.
// Bins are written into the back bank; once the last bin of a frame lands,
// the banks swap at the next start of vertical blanking. The front bank is
// read with a fixed 2-cycle pipeline and each bin is replicated over a
// (1<<SCALE_LOG2) square block.
// Ports:
//   clk_in : pixel clock
//   rst_in : asynchronous active-high reset
//   bus    : binned_frame_upscaler_if.slave (write stream, display counters,
//            delayed video out, front bank index, sticky range error)
module binned_frame_upscaler #(
  parameter int H_BIN      = 320,
  parameter int V_BIN      = 180,
  parameter int SCALE_LOG2 = 2,
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 720
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  binned_frame_upscaler_if.slave   bus
);
  localparam int DEPTH  = H_BIN * V_BIN;
  localparam int STAGES = 1;

  localparam logic [8:0]  H_LIM  = 9'(H_BIN);
  localparam logic [7:0]  V_LIM  = 8'(V_BIN);
  localparam logic [8:0]  H_LAST = 9'(H_BIN - 1);
  localparam logic [7:0]  V_LAST = 8'(V_BIN - 1);
  localparam logic [10:0] HA_LIM = 11'(H_ACTIVE);
  localparam logic [9:0]  VA_LIM = 10'(V_ACTIVE);

  // v*320 + h as shift-add; wraps harmlessly for blanking coordinates
  function automatic logic [15:0] bin_addr(input logic [8:0] h, input logic [7:0] v);
    logic [15:0] vv;
    vv = {8'd0, v};
    return (vv << 8) + (vv << 6) + {7'd0, h};
  endfunction

  logic mem [2][DEPTH];

  logic              front, frame_done, have_frame, range_err;
  logic              in_range, wr_en, last_bin, swap_cyc, active;
  logic [15:0]       rd_addr;
  logic              rd_bank, rd_bit;
  logic [10:0]       h_s0, h_s1;
  logic [9:0]        v_s0, v_s1;
  logic [STAGES:0]   vld_pipe;

  assign in_range = (bus.bin_hcount_in < H_LIM) && (bus.bin_vcount_in < V_LIM);
  assign wr_en    = bus.bin_valid_in && in_range;
  assign last_bin = (bus.bin_hcount_in == H_LAST) && (bus.bin_vcount_in == V_LAST);
  assign swap_cyc = (bus.hcount_in == 11'd0) && (bus.vcount_in == VA_LIM);
  assign active   = (bus.hcount_in < HA_LIM) && (bus.vcount_in < VA_LIM);

  // Memory ports: no reset so both map onto block RAM
  always_ff @(posedge clk_in) begin
    if (wr_en)
      mem[~front][bin_addr(bus.bin_hcount_in, bus.bin_vcount_in)] <= bus.bin_pixel_in;
    rd_bit <= mem[rd_bank][rd_addr];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      front      <= 1'b0;
      frame_done <= 1'b0;
      have_frame <= 1'b0;
      range_err  <= 1'b0;
      rd_addr    <= '0;
      rd_bank    <= 1'b0;
      h_s0       <= '0;
      v_s0       <= '0;
      h_s1       <= '0;
      v_s1       <= '0;
      vld_pipe   <= '0;
    end else begin
      if (bus.bin_valid_in && !in_range)
        range_err <= 1'b1;
      // Registered frame_done: a last-bin write on the swap cycle itself
      // waits for the next blanking start.
      if (swap_cyc && frame_done) begin
        front      <= ~front;
        frame_done <= 1'b0;
        have_frame <= 1'b1;
      end else if (wr_en && last_bin) begin
        frame_done <= 1'b1;
      end
      // stage 0
      h_s0        <= bus.hcount_in;
      v_s0        <= bus.vcount_in;
      vld_pipe[0] <= active;
      rd_bank     <= front;
      rd_addr     <= bin_addr(bus.hcount_in[8+SCALE_LOG2:SCALE_LOG2],
                              bus.vcount_in[7+SCALE_LOG2:SCALE_LOG2]);
      // stage 1 (RAM read happens alongside)
      h_s1        <= h_s0;
      v_s1        <= v_s0;
      vld_pipe[1] <= vld_pipe[0];
    end
  end

  assign bus.hcount_out     = h_s1;
  assign bus.vcount_out     = v_s1;
  assign bus.valid_out      = vld_pipe[STAGES];
  // RAM data is not reset, so gate it with reset-cleared flags
  assign bus.pixel_out      = vld_pipe[STAGES] & have_frame & rd_bit;
  assign bus.front_bank_out = front;
  assign bus.range_err_out  = range_err;
endmodule
